// File: rtl/control_unit_pkg.sv
// control_unit_pkg: opcodes, ALU function codes, B-operand selects and FSM states shared with the datapath
package control_unit_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_LDA, OP_LDB, OP_MOV_AB, OP_MOV_BA, OP_ADD, OP_SUB, OP_AND,
    OP_OR, OP_XOR, OP_ADDI, OP_INC, OP_DEC, OP_CMP, OP_CLRA, OP_OUT
  } opcode_e;
  localparam logic [3:0] ALU_PASS_A = 4'd0;
  localparam logic [3:0] ALU_PASS_B = 4'd1;
  localparam logic [3:0] ALU_ADD    = 4'd2;
  localparam logic [3:0] ALU_SUB    = 4'd3;
  localparam logic [3:0] ALU_AND    = 4'd4;
  localparam logic [3:0] ALU_OR     = 4'd5;
  localparam logic [3:0] ALU_XOR    = 4'd6;
  localparam logic [1:0] BSEL_REG  = 2'b00;
  localparam logic [1:0] BSEL_IMM  = 2'b01;
  localparam logic [1:0] BSEL_ONE  = 2'b10;
  localparam logic [1:0] BSEL_ZERO = 2'b11;
  localparam logic [3:0] WR_A  = 4'b1000;
  localparam logic [3:0] WR_B  = 4'b0100;
  localparam logic [3:0] WR_O  = 4'b0010;
  localparam logic [3:0] WR_CZ = 4'b0001;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
endpackage

// File: rtl/control_unit_decoder.sv
// control_unit_decoder: combinational instruction decode to ALU function, B select and write strobes {a,b,o,cz}
module control_unit_decoder
  import control_unit_pkg::*;
(
  input  logic [3:0] ir,
  output logic [3:0] f,
  output logic [1:0] b_sel,
  output logic [3:0] wr
);
  always_comb begin
    f = ALU_PASS_A;
    b_sel = BSEL_REG;
    wr = '0;
    case (opcode_e'(ir))
      OP_NOP:    begin f = ALU_PASS_A; b_sel = BSEL_REG;  wr = '0;            end
      OP_LDA:    begin f = ALU_PASS_B; b_sel = BSEL_IMM;  wr = WR_A;          end
      OP_LDB:    begin f = ALU_PASS_B; b_sel = BSEL_IMM;  wr = WR_B;          end
      OP_MOV_AB: begin f = ALU_PASS_B; b_sel = BSEL_REG;  wr = WR_A;          end
      OP_MOV_BA: begin f = ALU_PASS_A; b_sel = BSEL_REG;  wr = WR_B;          end
      OP_ADD:    begin f = ALU_ADD;    b_sel = BSEL_REG;  wr = WR_A | WR_CZ;  end
      OP_SUB:    begin f = ALU_SUB;    b_sel = BSEL_REG;  wr = WR_A | WR_CZ;  end
      OP_AND:    begin f = ALU_AND;    b_sel = BSEL_REG;  wr = WR_A | WR_CZ;  end
      OP_OR:     begin f = ALU_OR;     b_sel = BSEL_REG;  wr = WR_A | WR_CZ;  end
      OP_XOR:    begin f = ALU_XOR;    b_sel = BSEL_REG;  wr = WR_A | WR_CZ;  end
      OP_ADDI:   begin f = ALU_ADD;    b_sel = BSEL_IMM;  wr = WR_A | WR_CZ;  end
      OP_INC:    begin f = ALU_ADD;    b_sel = BSEL_ONE;  wr = WR_A | WR_CZ;  end
      OP_DEC:    begin f = ALU_SUB;    b_sel = BSEL_ONE;  wr = WR_A | WR_CZ;  end
      OP_CMP:    begin f = ALU_SUB;    b_sel = BSEL_REG;  wr = WR_CZ;         end
      OP_CLRA:   begin f = ALU_PASS_B; b_sel = BSEL_ZERO; wr = WR_A | WR_CZ;  end
      OP_OUT:    begin f = ALU_PASS_A; b_sel = BSEL_REG;  wr = WR_O;          end
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: captures one opcode per execute press and pulses its write strobes for exactly one cycle
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       execute_n,
  input  logic [3:0] opcode,
  output logic [3:0] F,
  output logic [1:0] B_sel,
  output logic       write_a,
  output logic       write_b,
  output logic       write_o,
  output logic       write_cz
);
  logic [1:0] state;
  logic [3:0] ir;
  logic [3:0] wr;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      ir <= '0;
    end else begin
      case (state)
        S_IDLE: if (!execute_n) begin
          ir <= opcode;
          state <= S_EXEC;
        end
        S_EXEC: state <= execute_n ? S_IDLE : S_WAIT;
        S_WAIT: if (execute_n) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  control_unit_decoder u_dec (.ir(ir), .f(F), .b_sel(B_sel), .wr(wr));
  // strobes live only in EXEC, so holding the button cannot repeat a write
  assign {write_a, write_b, write_o, write_cz} = (state == S_EXEC) ? wr : 4'b0000;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: table-driven opcode sweep, hand-written press/hold/reset sequences and random stimulus against a press-level model
module tb_control_unit;
  logic clk = 1'b0;
  logic rstn;
  logic execute_n;
  logic [3:0] opcode;
  logic [3:0] F;
  logic [1:0] B_sel;
  logic write_a, write_b, write_o, write_cz;
  logic [9:0] obs;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0] op;
    logic [3:0] f;
    logic [1:0] bsel;
    logic [3:0] wr;
  } vec_t;
  vec_t tbl[16];
  logic [3:0] ir_m;
  bit armed_m;
  bit fire_m;
  int cnt;

  control_unit dut (
    .clk(clk), .rstn(rstn), .execute_n(execute_n), .opcode(opcode),
    .F(F), .B_sel(B_sel), .write_a(write_a), .write_b(write_b),
    .write_o(write_o), .write_cz(write_cz)
  );

  always #5 clk = ~clk;
  assign obs = {F, B_sel, write_a, write_b, write_o, write_cz};

  function automatic logic [9:0] expv();
    return {tbl[ir_m].f, tbl[ir_m].bsel, fire_m ? tbl[ir_m].wr : 4'b0000};
  endfunction

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got F=%b B_sel=%b wr(a,b,o,cz)=%b, want F=%b B_sel=%b wr=%b",
               name, got[9:6], got[5:4], got[3:0], exp[9:6], exp[5:4], exp[3:0]);
    end
  endtask

  task automatic model_reset();
    ir_m = 4'd0;
    armed_m = 1'b1;
    fire_m = 1'b0;
  endtask

  // one press executes once; the button must be seen released before the next press counts
  task automatic step(input string name);
    @(posedge clk);
    fire_m = armed_m && !execute_n;
    if (fire_m) ir_m = opcode;
    armed_m = fire_m ? 1'b0 : (armed_m | execute_n);
    #1;
    chk(name, obs, expv());
  endtask

  initial begin
    tbl[0]  = '{4'd0,  4'b0000, 2'b00, 4'b0000};
    tbl[1]  = '{4'd1,  4'b0001, 2'b01, 4'b1000};
    tbl[2]  = '{4'd2,  4'b0001, 2'b01, 4'b0100};
    tbl[3]  = '{4'd3,  4'b0001, 2'b00, 4'b1000};
    tbl[4]  = '{4'd4,  4'b0000, 2'b00, 4'b0100};
    tbl[5]  = '{4'd5,  4'b0010, 2'b00, 4'b1001};
    tbl[6]  = '{4'd6,  4'b0011, 2'b00, 4'b1001};
    tbl[7]  = '{4'd7,  4'b0100, 2'b00, 4'b1001};
    tbl[8]  = '{4'd8,  4'b0101, 2'b00, 4'b1001};
    tbl[9]  = '{4'd9,  4'b0110, 2'b00, 4'b1001};
    tbl[10] = '{4'd10, 4'b0010, 2'b01, 4'b1001};
    tbl[11] = '{4'd11, 4'b0010, 2'b10, 4'b1001};
    tbl[12] = '{4'd12, 4'b0011, 2'b10, 4'b1001};
    tbl[13] = '{4'd13, 4'b0011, 2'b00, 4'b0001};
    tbl[14] = '{4'd14, 4'b0001, 2'b11, 4'b1001};
    tbl[15] = '{4'd15, 4'b0000, 2'b00, 4'b0010};
    rstn = 1'b0;
    execute_n = 1'b1;
    opcode = 4'd0;
    model_reset();
    #2;
    chk("reset", obs, 10'b0);
    @(posedge clk);
    #1 rstn = 1'b1;
    step("idle");
    for (int i = 0; i < 16; i++) begin
      opcode = tbl[i].op;
      execute_n = 1'b0;
      step($sformatf("sweep_op%0d", i));
      chk($sformatf("sweep_tbl%0d", i), obs, {tbl[i].f, tbl[i].bsel, tbl[i].wr});
      execute_n = 1'b1;
      opcode = ~tbl[i].op;
      step($sformatf("sweep_rel%0d", i));
      chk($sformatf("sweep_off%0d", i), {6'b0, obs[3:0]}, 10'b0);
    end
    opcode = 4'd1;
    execute_n = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step("hold");
      cnt += int'(write_a);
      chk("hold_fb", {obs[9:4], 4'b0}, {4'b0001, 2'b01, 4'b0});
    end
    execute_n = 1'b1;
    step("hold_rel");
    chk("hold_count", 10'(cnt), 10'd1);
    opcode = 4'd1;
    execute_n = 1'b0;
    step("wait_press");
    step("wait_enter");
    opcode = 4'd15;
    step("wait_ign0");
    step("wait_ign1");
    chk("wait_f", obs, {4'b0001, 2'b01, 4'b0000});
    execute_n = 1'b1;
    step("wait_rel");
    execute_n = 1'b0;
    step("wait_repress");
    chk("wait_out", obs, {4'b0000, 2'b00, 4'b0010});
    execute_n = 1'b1;
    step("wait_done");
    opcode = 4'd5;
    execute_n = 1'b0;
    step("rst_pre");
    rstn = 1'b0;
    #1;
    model_reset();
    chk("rst_exec", obs, 10'b0);
    #9 rstn = 1'b1;
    chk("rst_held", obs, 10'b0);
    step("rst_repress");
    chk("rst_repress_add", obs, {4'b0010, 2'b00, 4'b1001});
    execute_n = 1'b1;
    step("rst_rel");
    for (int i = 0; i < 400; i++) begin
      execute_n = 1'($urandom_range(0, 1));
      opcode = 4'($urandom_range(0, 15));
      step("random");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
